// File: rtl/tt_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt_capture_pkg
// Description : Shared types and helpers for the truth-table capture block:
//               FSM state encoding, table-width helper and the mapping from
//               an input combination to its bit position in the table code.
// Revision    : 1.0 - initial release
// ============================================================================
package tt_capture_pkg;

  // Default number of DUT inputs and the resulting truth-table width
  localparam int TT_N_IN = 3;
  localparam int TT_W    = 2 ** TT_N_IN;

  // Capture sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } tt_state_e;

  // Table width for a given number of DUT inputs
  function automatic int unsigned tt_width(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

  // Combination 0 lands in the MSB so the captured code reads like the
  // benchmark's hex name (e.g. 0x87).
  function automatic int unsigned tt_bit_index(input int unsigned combo,
                                               input int unsigned n_in = TT_N_IN);
    return tt_width(n_in) - 32'd1 - combo;
  endfunction

endpackage : tt_capture_pkg
`default_nettype wire

// File: rtl/tt_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : tt_settle_timer
// Description : Loadable down-counter. Counts down while enabled and stops
//               at zero; the terminal-count flag is high at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_settle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  // Load wins over counting; the count saturates at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tc = (r_count == '0);

endmodule : tt_settle_timer
`default_nettype wire

// File: rtl/truth_table_capture.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_capture
// Description : Sweeps every input combination into a combinational DUT,
//               holds each for a programmable settle time, samples the DUT
//               output and assembles the truth-table code. The captured code
//               is compared against a reference latched at start.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_capture
  import tt_capture_pkg::*;
#(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      probe_out,
  input  logic                 probe_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 valid,
  output logic                 match
);

  localparam int              c_tt_w        = 2 ** N_IN;
  // The timer counts SETTLE_CYCLES-1 down to zero while in SETTLE
  localparam logic [7:0]      c_settle_load = 8'(SETTLE_CYCLES - 1);

  tt_state_e             r_state;
  logic [N_IN-1:0]       r_combo;
  logic [c_tt_w-1:0]     r_shadow;
  logic [c_tt_w-1:0]     r_expected;
  logic [N_IN-1:0]       r_probe;
  logic                  r_busy;
  logic                  r_done;
  logic [c_tt_w-1:0]     r_table;
  logic                  r_valid;
  logic                  r_match;

  logic                  w_timer_load;
  logic                  w_timer_en;
  logic                  w_settled;
  logic                  w_last;
  logic [N_IN-1:0]       w_bit_idx;
  logic [c_tt_w-1:0]     w_shadow_next;

  assign w_last    = &r_combo;
  assign w_bit_idx = N_IN'(tt_bit_index(32'(r_combo), N_IN));

  // Shadow table with the current sample merged in, used on SAMPLE cycles
  always_comb begin
    w_shadow_next            = r_shadow;
    w_shadow_next[w_bit_idx] = probe_in;
  end

  // Reload the settle timer whenever a new combination starts being driven
  assign w_timer_load = ((r_state == ST_IDLE) && start) ||
                        ((r_state == ST_SAMPLE) && !abort && !w_last);
  assign w_timer_en   = (r_state == ST_SETTLE);

  tt_settle_timer #(
    .W (8)
  ) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_timer_load),
    .i_load_val (c_settle_load),
    .i_en       (w_timer_en),
    .o_tc       (w_settled)
  );

  // Sweep sequencer; every output is registered and updated alongside state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_combo    <= '0;
      r_shadow   <= '0;
      r_expected <= '0;
      r_probe    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_table    <= '0;
      r_valid    <= 1'b0;
      r_match    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          // start beats a simultaneous abort; abort alone does nothing here
          if (start) begin
            r_expected <= expected;
            r_combo    <= '0;
            r_shadow   <= '0;
            r_probe    <= '0;
            r_valid    <= 1'b0;
            r_match    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (abort) begin
            r_probe <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_settled) begin
            r_state <= ST_SAMPLE;
          end
        end

        ST_SAMPLE: begin
          if (abort) begin
            r_probe <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_shadow <= w_shadow_next;
            if (w_last) begin
              // Publish results so they appear together with the done pulse
              r_table <= w_shadow_next;
              r_match <= (w_shadow_next == r_expected);
              r_valid <= 1'b1;
              r_done  <= 1'b1;
              r_probe <= '0;
              r_busy  <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              r_combo <= r_combo + 1'b1;
              r_probe <= r_combo + 1'b1;
              r_state <= ST_SETTLE;
            end
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign probe_out = r_probe;
  assign busy      = r_busy;
  assign done      = r_done;
  assign table_out = r_table;
  assign valid     = r_valid;
  assign match     = r_match;

endmodule : truth_table_capture
`default_nettype wire

// File: tb/tb_truth_table_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_capture
// Description : Self-checking bench for truth_table_capture. Two instances
//               (settle 4 and settle 1) each sweep a behavioural 3-input DUT
//               described by its per-combination output vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_capture;
  import tt_capture_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  // instance 0: SETTLE_CYCLES = 4, instance 1: SETTLE_CYCLES = 1
  logic       start4, abort4, start1, abort1;
  logic [7:0] exp4, exp1;
  logic [2:0] probe4, probe1;
  logic       pin4, pin1;
  logic       busy4, busy1, done4, done1, valid4, valid1, match4, match1;
  logic [7:0] table4, table1;

  // fn[c] is the DUT output for input combination c = {in1,in2,in3}
  logic [7:0] fn4, fn1;
  assign pin4 = fn4[probe4];
  assign pin1 = fn1[probe1];

  truth_table_capture #(.N_IN(3), .SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort4), .expected(exp4),
    .probe_out(probe4), .probe_in(pin4), .busy(busy4), .done(done4),
    .table_out(table4), .valid(valid4), .match(match4));

  truth_table_capture #(.N_IN(3), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .expected(exp1),
    .probe_out(probe1), .probe_in(pin1), .busy(busy1), .done(done1),
    .table_out(table1), .valid(valid1), .match(match1));

  int         n_total = 0;
  int         n_pass  = 0;
  logic [7:0] model_table [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, req);
  endtask

  // Reference: the code lists combination 0's output first (MSB)
  function automatic logic [7:0] ref_table(input logic [7:0] fn);
    logic [7:0] t;
    t = '0;
    for (int c = 0; c < 8; c++) t[tt_bit_index(c)] = fn[c];
    return t;
  endfunction

  task automatic drive(input int sel, input logic s, input logic a);
    if (sel == 0) begin start4 = s; abort4 = a; end
    else          begin start1 = s; abort1 = a; end
  endtask

  // Called at a negedge; start is presented in this cycle (cycle t).
  // abort_at / rst_at / extra_start_at are cycle offsets from t (0 = unused).
  task automatic run_sweep(input int sel, input logic [7:0] fn, input logic [7:0] expv,
                           input logic [7:0] want_tbl, input logic want_match,
                           input int abort_at, input int rst_at, input int extra_start_at,
                           input logic abort_with_start, input string tag);
    int         s_cyc, len, stop, last;
    logic [7:0] prev;
    logic [13:0] act, req;
    logic        act_match;
    s_cyc = (sel == 0) ? 4 : 1;
    len   = 8 * (s_cyc + 1);
    stop  = (abort_at > 0) ? abort_at : rst_at;
    last  = (stop > 0) ? stop + 2 : len + 2;
    prev  = model_table[sel];
    if (sel == 0) begin fn4 = fn; exp4 = expv; end
    else          begin fn1 = fn; exp1 = expv; end
    drive(sel, 1'b1, abort_with_start);
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      // expected {busy, done, valid, probe, table} in cycle t+n
      if (stop > 0 && n > stop)
        req = {3'b000, 3'd0, (rst_at > 0) ? 8'h00 : prev};
      else if (n <= len)
        req = {3'b100, 3'((n - 1) / (s_cyc + 1)), prev};
      else if (n == len + 1)
        req = {3'b011, 3'd0, want_tbl};
      else
        req = {3'b001, 3'd0, want_tbl};
      act       = (sel == 0) ? {busy4, done4, valid4, probe4, table4}
                             : {busy1, done1, valid1, probe1, table1};
      act_match = (sel == 0) ? match4 : match1;
      chk($sformatf("%s cyc%0d", tag, n), 32'(act), 32'(req));
      if (stop == 0 && n == len + 1)
        chk($sformatf("%s match", tag), 32'(act_match), 32'(want_match));
      if (rst_at > 0 && n == rst_at + 1)
        chk($sformatf("%s match after rst", tag), 32'(act_match), 32'd0);
      drive(sel, (n == extra_start_at), (n == abort_at));
      rst = (n == rst_at);
    end
    if (rst_at > 0) begin
      model_table[0] = 8'h00;
      model_table[1] = 8'h00;
    end else if (abort_at == 0) begin
      model_table[sel] = want_tbl;
    end
  endtask

  typedef struct {
    int         sel;
    logic [7:0] fn;
    logic [7:0] expv;
    logic [7:0] want_tbl;
    logic       want_match;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{sel: 0, fn: 8'hE1, expv: 8'h87, want_tbl: 8'h87, want_match: 1'b1};
    vecs[1] = '{sel: 0, fn: 8'hE1, expv: 8'h86, want_tbl: 8'h87, want_match: 1'b0};
    vecs[2] = '{sel: 1, fn: 8'hFF, expv: 8'hFF, want_tbl: 8'hFF, want_match: 1'b1};
    vecs[3] = '{sel: 1, fn: 8'h00, expv: 8'hFF, want_tbl: 8'h00, want_match: 1'b0};
    vecs[4] = '{sel: 0, fn: 8'h01, expv: 8'h80, want_tbl: 8'h80, want_match: 1'b1};
    vecs[5] = '{sel: 0, fn: 8'h80, expv: 8'h01, want_tbl: 8'h01, want_match: 1'b1};

    rst = 1'b1;
    start4 = 1'b0; abort4 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    exp4 = '0; exp1 = '0; fn4 = '0; fn1 = '0;
    model_table[0] = 8'h00;
    model_table[1] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset inst4", 32'({busy4, done4, valid4, match4, probe4, table4}), 32'd0);
    chk("reset inst1", 32'({busy1, done1, valid1, match1, probe1, table1}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle after reset", 32'({busy4, done4, valid4, busy1, done1, valid1}), 32'd0);

    // Table-driven sweeps
    for (int i = 0; i < 6; i++)
      run_sweep(vecs[i].sel, vecs[i].fn, vecs[i].expv, vecs[i].want_tbl,
                vecs[i].want_match, 0, 0, 0, 1'b0, $sformatf("vec%0d", i));

    // Multi-cycle corner cases
    run_sweep(0, 8'h0F, 8'hF0, 8'hF0, 1'b1, 12, 0, 0, 1'b0, "abort@12");
    run_sweep(0, 8'hE1, 8'h87, 8'h87, 1'b1, 0, 0, 5, 1'b0, "start@5 ignored");
    run_sweep(1, 8'hAA, 8'h55, 8'h55, 1'b1, 0, 0, 17, 1'b1, "start+abort idle");
    run_sweep(1, 8'h3C, 8'h3C, 8'h3C, 1'b1, 16, 0, 0, 1'b0, "abort last sample");
    run_sweep(0, 8'hE1, 8'h87, 8'h87, 1'b1, 0, 20, 0, 1'b0, "rst@20");
    run_sweep(0, 8'hE1, 8'h87, 8'h87, 1'b1, 0, 0, 0, 1'b0, "after rst");

    // Randomized sweeps checked against the reference model
    for (int r = 0; r < 10; r++) begin
      int         sel, ab;
      logic [7:0] fn, expv, want;
      sel  = int'($urandom_range(0, 1));
      fn   = 8'($urandom);
      want = ref_table(fn);
      expv = ($urandom_range(0, 1) == 0) ? want : 8'($urandom);
      ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, (sel == 0) ? 40 : 16)) : 0;
      run_sweep(sel, fn, expv, want, (want == expv), ab, 0, 0, 1'($urandom_range(0, 1)),
                $sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_truth_table_capture
`default_nettype wire

// File: doc/truth_table_capture.md
# truth_table_capture

Sequential characterizer for 3-input logic benchmarks, the reading end of the truth-table convention used by the combinational benchmark modules. It drives every input combination into a device under test (DUT) in order and waits a programmable settle time. It samples the DUT's single output and assembles the 8-bit truth-table code, for example `0x87`. It also compares the result against an expected code, so the test harness can check any benchmark module against its hex name.

## Interface
- `N_IN`, default 3: number of DUT inputs; table width is `2**N_IN`.
- `SETTLE_CYCLES`, default 4: cycles each combination is held before sampling; legal range 1..255.
- `clk`  in  1  the only clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- `abort`  in  1  cancels a sweep in progress.
- `expected`  in  `2**N_IN`  reference code; sampled when `start` is accepted.
- `probe_out`  out  `N_IN`  drives the DUT inputs as `{in1,in2,in3}`, MSB = `in1`.
- `probe_in`  in  1  DUT output `out`; must be synchronous to `clk`.
- `busy`  out  1  high from the cycle after `start` is accepted through the last SAMPLE cycle.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `table_out`  out  `2**N_IN`  captured code; valid when `valid` = 1.
- `valid`  out  1  set with `done`; cleared on `start` acceptance, `abort` or `rst`.
- `match`  out  1  `table_out == expected_latched`; meaningful only while `valid` = 1.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - On `start`, latch `expected`, clear `combo`, `settle_cnt`, `valid` and the shadow table, then go to SETTLE.
- SETTLE:
  - `probe_out = combo`.
  - `settle_cnt` increments every cycle; move to SAMPLE when it reaches `SETTLE_CYCLES-1`.
- SAMPLE:
  - Write `probe_in` into shadow bit `[2**N_IN-1-combo]`, so combination 000 maps to the MSB. This bit ordering gives `0x87` for the standard 0x87 benchmark.
  - If `combo` is all ones, go to DONE. Otherwise increment `combo`, clear `settle_cnt` and go to SETTLE.
- DONE (one cycle):
  - Copy the shadow table to `table_out`.
  - Set `valid`, compute `match` and pulse `done`.
  - Return to IDLE.
- `probe_out` is held at 0 in IDLE and DONE.
- `abort` in SETTLE or SAMPLE returns to IDLE next cycle. `table_out` keeps its previous value, `valid` = 0, and no `done` pulse is issued. `abort` in IDLE or DONE is ignored.
- `start` outside IDLE is ignored and not queued. If `start` and `abort` arrive in the same IDLE cycle, `start` wins.
- `table_out`, `valid` and `match` are stable between sweeps.

## Timing
- Reset values: state IDLE; `probe_out` = 0, `busy` = 0, `done` = 0, `table_out` = 0, `valid` = 0, `match` = 0.
- `rst` mid-sweep takes priority over everything. The block is in IDLE with reset values on the next cycle.
- Let `start` be accepted at cycle t. Each combination occupies `SETTLE_CYCLES+1` cycles.
  - Combination k is driven from cycle t+1+k·(S+1).
  - Combination k is sampled at cycle t+(k+1)·(S+1).
  - `done` and `valid` rise at cycle t+1+8·(S+1). With S = 4 that is t+41.
- `probe_out` changes only on the cycle after a SAMPLE. The DUT sees each value for exactly S+1 cycles.
- A new `start` can be accepted in the cycle after DONE.

## Structure
- Package `tt_capture_pkg`:
  - State enum.
  - `TT_W = 2**N_IN` helper.
  - Function `tt_bit_index(combo)` returning `2**N_IN-1-combo`. The testbench reuses this function.
- Sub-module `tt_settle_timer`: loadable down-counter with a terminal-count flag.
- Everything else stays in one module.

## Test plan
- DUT = 0x87 benchmark, S = 4, `expected` = 0x87, `start` at t:
  - `probe_out` steps through 0..7, each held for 5 cycles.
  - `done` at t+41; `table_out` = 0x87, `match` = 1.
- Same DUT, `expected` = 0x86 → `table_out` = 0x87, `match` = 0, `valid` = 1.
- S = 1, DUT tied to 1 → `table_out` = 0xFF at t+17. Then DUT tied to 0 and a second `start` → `table_out` = 0x00, `valid` low in between.
- `abort` at t+12 → IDLE at t+13, `busy` = 0, no `done`, `table_out` keeps its prior value.
- `start` pulsed at t+5 during a sweep → ignored; single `done` at t+41.
- `rst` at t+20 → next cycle all outputs at reset values; a fresh `start` then completes normally.
